// File: rtl/sync_link_pkg.sv
// -----------------------------------------------------------------------------
// sync_link_pkg
// Shared definitions for the sync-word serial link: the transmitter state
// encoding, the default sync header, and the 1101 sequence constant that both
// det_moore and sync_frame_tx use, so the two ends cannot drift apart.
// -----------------------------------------------------------------------------
package sync_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_GAP    = 3'd4
    } sync_state_t;

    // The one definition of the link's sync sequence.
    localparam logic [3:0] SEQ_1101 = 4'b1101;

    localparam int                    SYNC_W_DEF   = 4;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = SEQ_1101;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_frame_piso.sv
// -----------------------------------------------------------------------------
// sync_frame_piso
// Loadable MSB-first parallel-in / serial-out shift register. Zeros are shifted
// in at the LSB, so once every loaded bit has been shifted out the serial
// output rests at 0 without any extra gating.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset, clears the register
//   load      capture load_val (has priority over shift)
//   shift     shift left by one, 0 into the LSB
//   load_val  parallel word to load
//   msb       current MSB (the serial output bit)
// -----------------------------------------------------------------------------
module sync_frame_piso #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_val;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// -----------------------------------------------------------------------------
// sync_frame_tx
// Bit-serial frame transmitter. Each word accepted on the valid/ready
// handshake is sent on dout as SYNC_PAT (MSB first), then the payload
// (MSB first), then GAP idle-zero bit times. Drives det_moore's din.
//
// Optional feature, macro SYNC_FRAME_TX_PARITY_EN: when defined, one even
// parity bit (XOR of the payload) follows the payload with frame_act=1,
// lengthening the frame period by one cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_data    payload word
//   in_valid   payload word valid
//   in_ready   block can accept a word this cycle (IDLE and not in reset)
//   dout       serial line, registered
//   frame_act  registered, high while a sync/payload/parity bit is on dout
//   busy       registered, high in any state other than IDLE
// -----------------------------------------------------------------------------
module sync_frame_tx
    import sync_link_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
    parameter int                GAP      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dout,
    output logic              frame_act,
    output logic              busy
);

`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // Whole frame (header + payload [+ parity]) lives in one shift register,
    // loaded at the handshake; the payload waits behind the header.
    localparam int SR_W  = SYNC_W + DATA_W + PAR_W;
    localparam int CNT_W = $clog2(max_of(max_of(SYNC_W, DATA_W), max_of(GAP, 2))) + 1;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    // Where the FSM goes once the last serial bit of a frame is out.
    localparam sync_state_t ST_POST = (GAP > 0) ? ST_GAP : ST_IDLE;

    sync_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             xfer;
    logic             shift_en;
    logic [SR_W-1:0]  load_word;

    assign in_ready = (state == ST_IDLE) && !rst;
    assign xfer     = in_valid && in_ready;
    assign shift_en = (state == ST_SYNC) || (state == ST_DATA) || (state == ST_PARITY);

`ifdef SYNC_FRAME_TX_PARITY_EN
    assign load_word = {SYNC_PAT, in_data, ^in_data};
`else
    assign load_word = {SYNC_PAT, in_data};
`endif

    // ---------------- next-state / counter ----------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (xfer) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (cnt == SYNC_LAST) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (cnt == DATA_LAST) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_POST;
`endif
                    cnt_nxt   = '0;
                end
            end
            ST_PARITY: begin
                state_nxt = ST_POST;
                cnt_nxt   = '0;
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- state and registered status ----------------
    // Status flags are computed from state_nxt so they line up with the bit
    // the shift register presents in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            frame_act <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            frame_act <= (state_nxt == ST_SYNC) || (state_nxt == ST_DATA) ||
                         (state_nxt == ST_PARITY);
            busy      <= (state_nxt != ST_IDLE);
        end
    end

    // ---------------- serialiser ----------------
    // Loads only in IDLE, shifts once per frame bit; after SR_W shifts it is
    // all zeros, which keeps dout low through GAP and IDLE.
    sync_frame_piso #(
        .W (SR_W)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (xfer),
        .shift    (shift_en),
        .load_val (load_word),
        .msb      (dout)
    );

endmodule

// File: tb/tb_sync_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_sync_frame_tx
// Self-checking bench for sync_frame_tx. Handshakes push the expected serial
// frame to a queue; the monitor assembles frames from dout/frame_act and pops
// and compares. Honours SYNC_FRAME_TX_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_sync_frame_tx;

    localparam int         DATA_W   = 8;
    localparam int         SYNC_W   = 4;
    localparam int         GAP      = 1;
    localparam logic [3:0] SYNC_PAT = 4'b1101;
`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRM_W  = SYNC_W + DATA_W + PAR_W;
    localparam int PERIOD = 1 + FRM_W + GAP;
`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam logic [FRM_W-1:0] T1_FRAME = 13'b1101_10100101_0;
`else
    localparam logic [FRM_W-1:0] T1_FRAME = 12'b1101_10100101;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, dout, frame_act, busy;

    always #5 clk = ~clk;

    sync_frame_tx #(
        .DATA_W   (DATA_W),
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT),
        .GAP      (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .frame_act (frame_act),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FRM_W-1:0] mk_frame(input logic [DATA_W-1:0] d);
`ifdef SYNC_FRAME_TX_PARITY_EN
        return {SYNC_PAT, d, ^d};
`else
        return {SYNC_PAT, d};
`endif
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [FRM_W-1:0] exp_q[$];
    logic [FRM_W-1:0] rx_bits    = '0;
    logic [FRM_W-1:0] last_frame = '0;
    logic [FRM_W-1:0] exp_f;
    logic [3:0]       det_sr     = '0;
    int rx_idx = 0, frames_rx = 0, hs_cnt = 0, cyc = 0;
    int det_hits = 0, det_aligned = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            rx_idx = 0;
            det_sr = '0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(mk_frame(in_data));
                hs_cnt++;
            end
            det_sr = {det_sr[2:0], dout};
            if (frame_act) begin
                rx_bits = {rx_bits[FRM_W-2:0], dout};
                rx_idx++;
                if (det_sr == 4'b1101) begin
                    det_hits++;
                    if (rx_idx == SYNC_W) det_aligned++;
                end
                if (rx_idx == FRM_W) begin
                    chk("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        exp_f = exp_q.pop_front();
                        chk("frame", rx_bits, exp_f);
                    end
                    last_frame = rx_bits;
                    frames_rx++;
                    rx_idx = 0;
                end
            end else begin
                if (det_sr == 4'b1101) det_hits++;
                chk("dout_idle", dout, 0);
                if (rx_idx != 0) begin
                    chk("frame_len", rx_idx, FRM_W);
                    rx_idx = 0;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send_one(input logic [DATA_W-1:0] d, output int hs_at);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) chk("hs_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        hs_at = cyc;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        chk(tag, (exp_q.size() == 0) && !busy, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, hs0, rx0, h0, a0, fa_cnt, rdy_at;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_dout", dout, 0);
        chk("rst_frame_act", frame_act, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // ---- single word A5: timing ----
        send_one(8'hA5, t0);
        in_valid = 1'b0;
        fa_cnt = 0;
        rdy_at = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) chk("t1_ready_drop", in_ready, 0);
            if (frame_act) fa_cnt++;
            if (in_ready) begin
                rdy_at = n;
                break;
            end
        end
        chk("t1_ready_at", rdy_at, PERIOD);
        chk("t1_fa_cycles", fa_cnt, FRM_W);
        chk("t1_frame_bits", last_frame, T1_FRAME);
        @(posedge clk);
        #1;

        // ---- back-to-back with in_valid held high ----
        send_one(8'h00, t0);
        send_one(8'hFF, t1);
        send_one(8'h3C, t2);
        in_valid = 1'b0;
        chk("t2_period_a", t1 - t0, PERIOD);
        chk("t2_period_b", t2 - t1, PERIOD);
        drain("t2_drain");

        // ---- loopback detector: five 00 payloads ----
        h0 = det_hits;
        a0 = det_aligned;
        for (int i = 0; i < 5; i++) send_one(8'h00, t0);
        in_valid = 1'b0;
        drain("t3_drain");
        chk("t3_det_hits", det_hits - h0, 5);
        chk("t3_det_aligned", det_aligned - a0, 5);

        // ---- reset in the middle of an FF frame, with a competing handshake ----
        send_one(8'hFF, t0);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        chk("t4_ready_in_rst", in_ready, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_dout", dout, 0);
        chk("t4_frame_act", frame_act, 0);
        chk("t4_busy", busy, 0);
        chk("t4_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rx0 = frames_rx;
        send_one(8'h5A, t0);
        in_valid = 1'b0;
        drain("t4_drain");
        chk("t4_next_frame", frames_rx - rx0, 1);
        chk("t4_next_bits", last_frame, mk_frame(8'h5A));

        // ---- random in_valid / in_data churn ----
        hs0 = hs_cnt;
        rx0 = frames_rx;
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = DATA_W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain("t5_drain");
        chk("t5_some_hs", (hs_cnt - hs0) > 2, 1);
        chk("t5_rx_eq_hs", frames_rx - rx0, hs_cnt - hs0);

`ifdef SYNC_FRAME_TX_PARITY_EN
        // ---- parity bit ----
        send_one(8'h07, t0);
        in_valid = 1'b0;
        drain("t6_drain_a");
        chk("t6_par_07", last_frame[0], 1);
        send_one(8'h03, t0);
        in_valid = 1'b0;
        drain("t6_drain_b");
        chk("t6_par_03", last_frame[0], 0);
`endif

        chk("sb_final_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
